main_fsm: RTL and testbench
===========================

# main_fsm

Multicycle main controller for the RISC-V core: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback cycles, and drives the datapath multiplexer selects and write strobes. It sits directly upstream of the ALU decoder and supplies its `ALUOp`. A memory-ready handshake lets fetch and load/store cycles stall on slow memory.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `op` input 7: opcode, instr[6:0], from the instruction register.
- `mem_ready` input 1: memory completes the current access this cycle.
- `AdrSrc` output 1: memory address select; 0 = PC, 1 = ALU result register.
- `IRWrite` output 1: instruction-register and OldPC load strobe.
- `ALUSrcA` output 2: 00 = PC, 01 = OldPC, 10 = rs1 register.
- `ALUSrcB` output 2: 00 = rs2 register, 01 = immediate, 10 = constant 4.
- `ALUOp` output 2: to the ALU decoder; 00 = add, 01 = subtract, 10 = funct-decoded.
- `ResultSrc` output 2: 00 = ALUOut, 01 = read data, 10 = ALU result.
- `PCUpdate` output 1: unconditional PC write.
- `Branch` output 1: conditional PC write, qualified downstream with Zero.
- `RegWrite` output 1: register-file write strobe.
- `MemWrite` output 1: data-memory write strobe.
- `instr_retire` output 1: single-cycle pulse on the last cycle of each instruction.
- `illegal` output 1: sticky illegal-opcode flag. Present only with the configuration macro.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, plus ERROR when the macro is defined.
- State encoding is 4-bit binary. The state register is the only storage; apart from `mem_ready` gating, outputs decode from state alone.
- Any output not listed for a state is 0.
- FETCH
  - Outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite = PCUpdate = mem_ready.
  - Holds while !mem_ready; goes to DECODE when mem_ready=1.
- DECODE
  - Outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ.
  - Any other op -> illegal-opcode handling (see Configuration).
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. op=0000011 -> MEMREAD; otherwise -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite stays asserted through the stall. -> FETCH when mem_ready.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. -> ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. -> ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. -> FETCH.
- `instr_retire` is asserted in MEMWB, ALUWB, BEQ, and in MEMWRITE when mem_ready=1.

## Timing
- Reset asserted (asynchronous): state = FETCH immediately. While reset_n=0, IRWrite, PCUpdate, RegWrite, MemWrite and instr_retire are forced to 0; `illegal` = 0.
- Reset deasserted: the first rising edge with mem_ready=1 completes the first fetch.
- Cycle counts with zero wait states (mem_ready held at 1): lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Reset asserted mid-instruction aborts it; no strobe fires after reset_n falls.
- `mem_ready` is ignored in every state other than FETCH, MEMREAD and MEMWRITE.

## Configuration
- `MAIN_FSM_ILLEGAL_TRAP_EN` defined:
  - An unrecognised op in DECODE -> ERROR.
  - ERROR drives all strobes to 0, sets `illegal`=1, and holds until reset.
- Macro undefined:
  - An unrecognised op in DECODE -> FETCH, giving a 2-cycle no-op with PC already advanced by 4.
  - No ERROR state and no `illegal` port exist.

## Test plan
- Reset with mem_ready=1, op=0110011: states FETCH, DECODE, EXECUTER, ALUWB, FETCH. ALUOp=10 in EXECUTER; RegWrite=1 and instr_retire=1 only in ALUWB.
- lw (op=0000011) with mem_ready low for 2 cycles in MEMREAD: 7 cycles total. RegWrite pulses once, in MEMWB with ResultSrc=01.
- sw (op=0100011) with mem_ready low for 1 cycle in MEMWRITE: MemWrite=1 for 2 consecutive cycles, AdrSrc=1, RegWrite never asserted.
- beq (op=1100011): 3 cycles. Branch=1 and ALUOp=01 in BEQ. jal: PCUpdate=1 in JAL, then RegWrite in ALUWB.
- reset_n pulsed low during EXECUTEI: outputs return to FETCH values with all strobes 0 in the same cycle; no RegWrite occurs.
- op=1111111 with the macro defined: `illegal`=1 after DECODE and stays set for 10 cycles. Without the macro: return to FETCH after DECODE.

Source files
------------

// File: rtl/main_fsm.sv
// ============================================================================
// Module      : main_fsm
// Description : Multicycle RISC-V main controller (Moore FSM) with a memory
//               ready handshake. Define MAIN_FSM_ILLEGAL_TRAP_EN to trap
//               unrecognised opcodes in a sticky ERROR state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module main_fsm (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic       instr_retire
);

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE = 7'b0010011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        S_BEQ      = 4'd10,
        S_ERROR    = 4'd11
`else
        S_BEQ      = 4'd10
`endif
    } state_t;

    state_t r_state;

    logic w_irwrite;
    logic w_pcupdate;
    logic w_branch;
    logic w_regwrite;
    logic w_memwrite;
    logic w_retire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    if ((op == c_OP_LOAD) || (op == c_OP_STORE)) r_state <= S_MEMADR;
                    else if (op == c_OP_RTYPE)                   r_state <= S_EXECUTER;
                    else if (op == c_OP_ITYPE)                   r_state <= S_EXECUTEI;
                    else if (op == c_OP_JAL)                     r_state <= S_JAL;
                    else if (op == c_OP_BEQ)                     r_state <= S_BEQ;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
                    else                                         r_state <= S_ERROR;
`else
                    // PC has already advanced, so this retires as a no-op
                    else                                         r_state <= S_FETCH;
`endif
                end
                S_MEMADR:   r_state <= (op == c_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
                S_EXECUTER: r_state <= S_ALUWB;
                S_EXECUTEI: r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_JAL:      r_state <= S_ALUWB;
                S_BEQ:      r_state <= S_FETCH;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
                S_ERROR:    r_state <= S_ERROR;
`endif
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        ResultSrc  = 2'b00;
        w_irwrite  = 1'b0;
        w_pcupdate = 1'b0;
        w_branch   = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_retire   = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                w_irwrite  = mem_ready;
                w_pcupdate = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
                w_retire   = mem_ready;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                w_pcupdate = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                ALUOp    = 2'b01;
                w_branch = 1'b1;
                w_retire = 1'b1;
            end
            default: begin
                AdrSrc = 1'b0;
            end
        endcase
    end

    // FETCH strobes follow mem_ready, so they must be masked while in reset
    assign IRWrite      = w_irwrite  & reset_n;
    assign PCUpdate     = w_pcupdate & reset_n;
    assign Branch       = w_branch   & reset_n;
    assign RegWrite     = w_regwrite & reset_n;
    assign MemWrite     = w_memwrite & reset_n;
    assign instr_retire = w_retire   & reset_n;

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    assign illegal = (r_state == S_ERROR);
`endif

endmodule

`default_nettype wire

// File: tb/tb_main_fsm.sv
// ============================================================================
// Module      : tb_main_fsm
// Description : Directed, table-driven self-checking bench for main_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_main_fsm;

    logic       clk;
    logic       reset_n;
    logic [6:0] op;
    logic       mem_ready;
    logic       AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, instr_retire;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int tests;
    int fails;

    main_fsm dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op           (op),
        .mem_ready    (mem_ready),
        .AdrSrc       (AdrSrc),
        .IRWrite      (IRWrite),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUOp        (ALUOp),
        .ResultSrc    (ResultSrc),
        .PCUpdate     (PCUpdate),
        .Branch       (Branch),
        .RegWrite     (RegWrite),
        .MemWrite     (MemWrite),
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        .illegal      (illegal),
`endif
        .instr_retire (instr_retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, PCUpdate, Branch, RegWrite, MemWrite, instr_retire}
    localparam logic [14:0] E_FETCH1 = {1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_FETCH0 = {1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_DECODE = {1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_MEMADR = {1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_MEMRD  = {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_MEMWB  = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic [14:0] E_MEMWR0 = {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [14:0] E_MEMWR1 = {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [14:0] E_EXR    = {1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_EXI    = {1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_ALUWB  = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic [14:0] E_JAL    = {1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_BEQ    = {1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct packed {
        logic [6:0]  op;
        logic        mr;
        logic [14:0] exp;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs [NVEC];

    function automatic logic [14:0] outs();
        return {AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
                PCUpdate, Branch, RegWrite, MemWrite, instr_retire};
    endfunction

    task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive inputs mid-cycle, check, then advance to just after the next edge
    task automatic step(input string name, input logic [6:0] o, input logic mr, input logic [14:0] exp);
        op        = o;
        mem_ready = mr;
        #1;
        chk(name, outs(), exp);
        @(posedge clk);
        #2;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // R-type, zero wait: 4 cycles
        vecs[0]  = '{OP_R,   1'b1, E_FETCH1};
        vecs[1]  = '{OP_R,   1'b1, E_DECODE};
        vecs[2]  = '{OP_R,   1'b1, E_EXR};
        vecs[3]  = '{OP_R,   1'b1, E_ALUWB};
        // lw with 2 stall cycles in MEMREAD: 7 cycles
        vecs[4]  = '{OP_LW,  1'b1, E_FETCH1};
        vecs[5]  = '{OP_LW,  1'b1, E_DECODE};
        vecs[6]  = '{OP_LW,  1'b1, E_MEMADR};
        vecs[7]  = '{OP_LW,  1'b0, E_MEMRD};
        vecs[8]  = '{OP_LW,  1'b0, E_MEMRD};
        vecs[9]  = '{OP_LW,  1'b1, E_MEMRD};
        vecs[10] = '{OP_LW,  1'b1, E_MEMWB};
        // sw with 1 stall cycle in MEMWRITE
        vecs[11] = '{OP_SW,  1'b1, E_FETCH1};
        vecs[12] = '{OP_SW,  1'b1, E_DECODE};
        vecs[13] = '{OP_SW,  1'b1, E_MEMADR};
        vecs[14] = '{OP_SW,  1'b0, E_MEMWR0};
        vecs[15] = '{OP_SW,  1'b1, E_MEMWR1};
        // I-type with a fetch stall; mem_ready ignored outside memory states
        vecs[16] = '{OP_I,   1'b0, E_FETCH0};
        vecs[17] = '{OP_I,   1'b1, E_FETCH1};
        vecs[18] = '{OP_I,   1'b0, E_DECODE};
        vecs[19] = '{OP_I,   1'b0, E_EXI};
        vecs[20] = '{OP_I,   1'b0, E_ALUWB};
        // jal: 4 cycles
        vecs[21] = '{OP_JAL, 1'b1, E_FETCH1};
        vecs[22] = '{OP_JAL, 1'b1, E_DECODE};
        vecs[23] = '{OP_JAL, 1'b0, E_JAL};
        vecs[24] = '{OP_JAL, 1'b1, E_ALUWB};
        // beq: 3 cycles
        vecs[25] = '{OP_BEQ, 1'b1, E_FETCH1};
        vecs[26] = '{OP_BEQ, 1'b1, E_DECODE};
        vecs[27] = '{OP_BEQ, 1'b1, E_BEQ};
        // back in FETCH, then decode of the next instruction
        vecs[28] = '{OP_R,   1'b1, E_FETCH1};
        vecs[29] = '{OP_R,   1'b1, E_DECODE};

        reset_n   = 1'b0;
        op        = OP_R;
        mem_ready = 1'b1;
        #1;
        chk("reset_async", outs(), E_FETCH0);
        @(posedge clk);
        #2;
        chk("reset_hold", outs(), E_FETCH0);
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        chk1("reset_illegal", illegal, 1'b0);
`endif
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            step($sformatf("vec%0d", i), vecs[i].op, vecs[i].mr, vecs[i].exp);
        end
        // finish the R-type left in flight by the last vector
        step("tail_exr", OP_R, 1'b1, E_EXR);
        step("tail_aluwb", OP_R, 1'b1, E_ALUWB);

        // reset pulsed during EXECUTEI aborts the instruction
        step("rst_fetch", OP_I, 1'b1, E_FETCH1);
        step("rst_decode", OP_I, 1'b1, E_DECODE);
        #1;
        chk("rst_in_exi", outs(), E_EXI);
        reset_n = 1'b0;
        #1;
        chk("rst_abort_now", outs(), E_FETCH0);
        @(posedge clk);
        #2;
        chk("rst_abort_hold", outs(), E_FETCH0);
        chk1("rst_no_regwrite", RegWrite, 1'b0);
        reset_n = 1'b1;
        step("rst_refetch", OP_I, 1'b1, E_FETCH1);
        step("rst_redecode", OP_I, 1'b1, E_DECODE);

        // illegal opcode
        step("ill_fetch_pre", OP_I, 1'b1, E_EXI);
        step("ill_aluwb_pre", OP_I, 1'b1, E_ALUWB);
        step("ill_fetch", OP_BAD, 1'b1, E_FETCH1);
        step("ill_decode", OP_BAD, 1'b1, E_DECODE);
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        for (int c = 0; c < 10; c++) begin
            mem_ready = c[0];
            op        = (c < 5) ? OP_BAD : OP_R;
            #1;
            chk($sformatf("err_outs%0d", c), outs(), 15'd0);
            chk1($sformatf("err_illegal%0d", c), illegal, 1'b1);
            @(posedge clk);
            #2;
        end
        reset_n = 1'b0;
        #1;
        chk1("err_reset_clear", illegal, 1'b0);
        reset_n = 1'b1;
        step("err_refetch", OP_R, 1'b1, E_FETCH1);
`else
        step("ill_nop_fetch", OP_R, 1'b1, E_FETCH1);
        step("ill_nop_decode", OP_R, 1'b1, E_DECODE);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
